// File: rtl/tt7_pkg.sv
// Shared constants and FSM state type for the tt7 truth-table sweeper.
package tt7_pkg;

  localparam int NUM_IN = 7;
  localparam int TT_W   = 128;
  localparam int CNT_W  = 8;
  localparam int WCNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SAMPLE,
    DONE
  } state_t;

endpackage

// File: rtl/tt7_pattern_gen.sv
// Pattern index and settle-wait counter for the tt7 sweeper.
// idx drives the network directly, so x is a clean register output.
import tt7_pkg::*;

module tt7_pattern_gen #(
  parameter int SETTLE_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              count,
  input  logic              in_sample,
  output logic [NUM_IN-1:0] idx,
  output logic              wait_done,
  output logic              last
);

  logic [WCNT_W-1:0] wcnt;

  // WAIT covers SETTLE_CYCLES cycles; the sampling cycle itself is the SAMPLE state.
  assign wait_done = (int'(wcnt) + 1) >= SETTLE_CYCLES;
  assign last      = in_sample && (idx == NUM_IN'(TT_W - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx  <= '0;
      wcnt <= '0;
    end else if (clear) begin
      idx  <= '0;
      wcnt <= '0;
    end else if (in_sample) begin
      wcnt <= '0;
      if (!last) begin
        idx <= idx + 1'b1;
      end
    end else if (count && !wait_done) begin
      wcnt <= wcnt + 1'b1;
    end
  end

endmodule

// File: rtl/tt7_sweeper.sv
// Truth-table sweeper for 7-input networks: drives all 128 patterns, samples f_in,
// hands the 128-bit table off on valid/ready. Optional stats via `TT7_STATS_EN.
import tt7_pkg::*;

module tt7_sweeper #(
  parameter int SETTLE_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic [NUM_IN-1:0] x,
  input  logic              f_in,
  output logic              tt_valid,
  input  logic              tt_ready,
  output logic [TT_W-1:0]   tt_data
`ifdef TT7_STATS_EN
  ,
  output logic [CNT_W-1:0]  ones_cnt,
  output logic              balanced
`endif
);

  // With no settle time each pattern is a single SAMPLE cycle, so WAIT is skipped.
  localparam state_t PATTERN_ENTRY = (SETTLE_CYCLES == 0) ? SAMPLE : WAIT;

  state_t            state;
  logic [NUM_IN-1:0] idx;
  logic              wait_done;
  logic              last;
  logic              accept;
  logic              handoff;
  logic              in_sample;

  assign accept    = (state == IDLE) && start;
  assign handoff   = (state == DONE) && tt_ready;
  assign in_sample = (state == SAMPLE);
  assign x         = idx;

  tt7_pattern_gen #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_pattern_gen (
    .clk      (clk),
    .rst      (rst),
    .clear    (accept || handoff),
    .count    (state == WAIT),
    .in_sample(in_sample),
    .idx      (idx),
    .wait_done(wait_done),
    .last     (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      tt_valid <= 1'b0;
      tt_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= PATTERN_ENTRY;
            busy  <= 1'b1;
          end
        end
        WAIT: begin
          if (wait_done) begin
            state <= SAMPLE;
          end
        end
        SAMPLE: begin
          tt_data[idx] <= f_in;
          if (last) begin
            state    <= DONE;
            tt_valid <= 1'b1;
          end else begin
            state <= PATTERN_ENTRY;
          end
        end
        DONE: begin
          if (tt_ready) begin
            state    <= IDLE;
            tt_valid <= 1'b0;
            busy     <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef TT7_STATS_EN
  logic [CNT_W-1:0] ones_next;

  assign ones_next = ones_cnt + CNT_W'(f_in);

  // Counted alongside each sample so the totals land in the same edge as tt_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ones_cnt <= '0;
      balanced <= 1'b0;
    end else if (accept) begin
      ones_cnt <= '0;
      balanced <= 1'b0;
    end else if (in_sample) begin
      ones_cnt <= ones_next;
      balanced <= (ones_next == CNT_W'(TT_W / 2));
    end
  end
`endif

endmodule

// File: tb/tb_tt7_sweeper.sv
// Self-checking bench for tt7_sweeper: SETTLE_CYCLES 0 and 2 instances against a
// truth-table reference model; stats checked when TT7_STATS_EN is defined.
module tb_tt7_sweeper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         start0, f0, ready0, busy0, valid0;
  logic [6:0]   x0;
  logic [127:0] data0;
  logic         start2, f2, ready2, busy2, valid2;
  logic [6:0]   x2;
  logic [127:0] data2;
`ifdef TT7_STATS_EN
  logic [7:0]   ones0, ones2;
  logic         bal0, bal2;
`endif

  int           checks = 0;
  int           failures = 0;
  int           mode0 = 0;
  int           mode2 = 0;
  logic [127:0] rnd0 = '0;
  logic [127:0] rnd2 = '0;
  logic [6:0]   xd1 = '0;
  logic [6:0]   xd2 = '0;

  tt7_sweeper #(.SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .busy(busy0), .x(x0), .f_in(f0),
    .tt_valid(valid0), .tt_ready(ready0), .tt_data(data0)
`ifdef TT7_STATS_EN
    , .ones_cnt(ones0), .balanced(bal0)
`endif
  );

  tt7_sweeper #(.SETTLE_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2), .x(x2), .f_in(f2),
    .tt_valid(valid2), .tt_ready(ready2), .tt_data(data2)
`ifdef TT7_STATS_EN
    , .ones_cnt(ones2), .balanced(bal2)
`endif
  );

  // Network response model: the Boolean function being characterised.
  function automatic logic model_f(int m, logic [6:0] v, logic [127:0] r);
    case (m)
      0: return v[0];
      1: return $countones({v[2], v[1], v[0]}) >= 2;
      2: return v[6];
      3: return 1'b1;
      4: return 1'b0;
      5: return r[v];
      6: return v[1];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [127:0] model_table(int m, logic [127:0] r);
    logic [127:0] t;
    for (int i = 0; i < 128; i++) t[i] = model_f(m, 7'(i), r);
    return t;
  endfunction

  assign f0 = model_f(mode0, x0, rnd0);

  // Registered network with two stages of latency in front of the 2-cycle-settle instance.
  always @(posedge clk) begin
    xd1 <= x2;
    xd2 <= xd1;
  end
  assign f2 = model_f(mode2, xd2, rnd2);

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic sweep0(input logic [127:0] exp, input int hold, input bit poke_busy, input bit poke_hs);
    int cyc;
    bit held;
    logic [127:0] snap;
    @(posedge clk); #1 start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    checkOutput("busy0_after_start", busy0, 1);
    cyc = 0;
    while (!valid0 && cyc < 1000) begin
      start0 = poke_busy && (cyc == 10 || cyc == 60 || cyc == 127);
      @(posedge clk); #1;
      cyc++;
    end
    start0 = 1'b0;
    checkOutput("latency0", cyc, 128);
    checkOutput("data0", data0, exp);
    checkOutput("x0_done", x0, 127);
`ifdef TT7_STATS_EN
    checkOutput("ones0", ones0, $countones(exp));
    checkOutput("bal0", bal0, $countones(exp) == 64);
`endif
    held = 1'b1;
    snap = data0;
    repeat (hold) begin
      @(posedge clk); #1;
      if (!valid0 || data0 !== snap) held = 1'b0;
    end
    if (hold > 0) checkOutput("hold0", held, 1);
    ready0 = 1'b1;
    start0 = poke_hs;
    @(posedge clk); #1;
    ready0 = 1'b0;
    start0 = 1'b0;
    checkOutput("valid0_after_hs", valid0, 0);
    checkOutput("busy0_after_hs", busy0, 0);
    checkOutput("x0_idle", x0, 0);
    @(posedge clk); #1;
    checkOutput("busy0_idle", busy0, 0);
    checkOutput("data0_retained", data0, exp);
  endtask

  task automatic sweep2(input logic [127:0] exp);
    int cyc, run, bad, nchg;
    logic [6:0] prev;
    @(posedge clk); #1 start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    cyc = 0; run = 0; bad = 0; nchg = 0;
    while (!valid2 && cyc < 2000) begin
      prev = x2;
      @(posedge clk); #1;
      cyc++;
      run++;
      if (x2 !== prev) begin
        if (run != 3) bad++;
        run = 0;
        nchg++;
      end
    end
    checkOutput("latency2", cyc, 384);
    checkOutput("data2", data2, exp);
    checkOutput("x2_hold_bad", bad, 0);
    checkOutput("x2_changes", nchg, 127);
`ifdef TT7_STATS_EN
    checkOutput("ones2", ones2, $countones(exp));
`endif
    ready2 = 1'b1;
    @(posedge clk); #1 ready2 = 1'b0;
    checkOutput("valid2_after_hs", valid2, 0);
    checkOutput("busy2_after_hs", busy2, 0);
  endtask

  task automatic applyStimulus();
    int cyc;
    mode0 = 0; sweep0({32{4'hA}}, 0, 1'b0, 1'b0);
    mode0 = 1; sweep0({16{8'hE8}}, 2, 1'b1, 1'b0);
    mode0 = 2; sweep0({{64{1'b1}}, {64{1'b0}}}, 0, 1'b0, 1'b0);
    mode0 = 3; sweep0({128{1'b1}}, 10, 1'b0, 1'b1);

    // Reset in the middle of a sweep discards everything.
    @(posedge clk); #1 start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    cyc = 0;
    while (x0 != 7'd50 && cyc < 500) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("reach50", x0, 50);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_x0", x0, 0);
    checkOutput("rst_busy0", busy0, 0);
    checkOutput("rst_data0", data0, 0);
    checkOutput("rst_valid0", valid0, 0);
    @(posedge clk); #1 rst = 1'b0;
    mode0 = 4; sweep0('0, 0, 1'b0, 1'b0);

    repeat (3) begin
      rnd0 = {$urandom, $urandom, $urandom, $urandom};
      mode0 = 5;
      sweep0(model_table(5, rnd0), int'($urandom_range(0, 4)), 1'b0, 1'b0);
    end

    mode2 = 6; sweep2({32{4'hC}});
    rnd2 = {$urandom, $urandom, $urandom, $urandom};
    mode2 = 5; sweep2(model_table(5, rnd2));
  endtask

  initial begin
    rst = 1'b1;
    start0 = 1'b0; ready0 = 1'b0;
    start2 = 1'b0; ready2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_x0", x0, 0);
    checkOutput("reset_busy0", busy0, 0);
    checkOutput("reset_valid0", valid0, 0);
    checkOutput("reset_data0", data0, 0);
    checkOutput("reset_valid2", valid2, 0);
`ifdef TT7_STATS_EN
    checkOutput("reset_ones0", ones0, 0);
    checkOutput("reset_bal0", bal0, 0);
`endif
    rst = 1'b0;
    applyStimulus();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
